// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: accepts one load/store, stalls for LATENCY wait cycles, pulses MemDone.
// Optional MEM_ALIGN_CHECK_EN adds the AlignErr port and rejects misaligned requests.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  MemStall,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  MemDone,
  output logic                  AlignErr
`else
  output logic                  MemDone
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT                 state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [DATA_WIDTH-1:0] dataQ;
  logic                  opWrite;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic request;
  logic commit;
  logic misaligned;

  assign request = MemRead | MemWrite;
  assign commit  = (state == WAIT) && (cnt == '0);

`ifdef MEM_ALIGN_CHECK_EN
  logic alignErrQ;
  assign misaligned = (Address[1:0] != 2'b00);
  assign AlignErr   = alignErrQ;
`else
  assign misaligned = 1'b0;
`endif

  // Upper address bits alias the array; the byte offset only matters for the alignment check.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  assign MemStall = Reset_n & (((state == IDLE) & request) | (state == WAIT));
  assign MemDone  = (state == DONE);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ReadData <= '0;
      addrQ    <= '0;
      dataQ    <= '0;
      opWrite  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      alignErrQ <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (request) begin
            addrQ   <= Address[ADDR_WIDTH+1:2];
            dataQ   <= WriteData;
            opWrite <= MemWrite;
            if (misaligned) begin
              state <= DONE;
`ifdef MEM_ALIGN_CHECK_EN
              alignErrQ <= 1'b1;
`endif
            end else begin
              cnt   <= CNT_W'(LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!opWrite) ReadData <= mem[addrQ];
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // The pipeline register still holds this request until this edge; do not re-accept it.
          state <= IDLE;
`ifdef MEM_ALIGN_CHECK_EN
          alignErrQ <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; a reset during the access suppresses the write.
  always_ff @(posedge Clk) begin
    if (Reset_n && commit && opWrite) mem[addrQ] <= dataQ;
  end

endmodule
